// File: rtl/mips_datapath_pkg.sv
// Shared decode constants and ALU helper for the single-cycle MIPS datapath.
package mips_datapath_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_NOP = 6'h00;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2a;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_ctl_e;

  function automatic logic [31:0] alu_op(alu_ctl_e ctl, logic [31:0] a, logic [31:0] b);
    logic [31:0] r;
    case (ctl)
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_SLT: r = {31'd0, $signed(a) < $signed(b)};
      default: r = a + b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mips_datapath_mem.sv
// Storage blocks: byte-wide instruction ROM, 32x32 register bank, word data RAM.
// None of them are reset so bench-preloaded contents survive rst_n.
module instr_mem #(
  parameter int IMEM_BYTES = 256
) (
  input  logic [31:0] pc_i,
  output logic [31:0] instr_o
);
  // Size is a power of two, so wrapping the byte address is just truncation.
  localparam int AW = $clog2(IMEM_BYTES);

  logic [7:0]    MR [IMEM_BYTES];
  logic [AW-1:0] a;
  logic          unused_pc;

  assign a         = pc_i[AW-1:0];
  assign unused_pc = ^pc_i[31:AW];
  assign instr_o   = {MR[a], MR[a + AW'(1)], MR[a + AW'(2)], MR[a + AW'(3)]};
endmodule

module reg_bank (
  input  logic        clk,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o
);
  logic [31:0] mem [32];

  assign rdata1_o = (raddr1_i == 5'd0) ? 32'd0 : mem[raddr1_i];
  assign rdata2_o = (raddr2_i == 5'd0) ? 32'd0 : mem[raddr2_i];

  always_ff @(posedge clk)
    if (we_i && waddr_i != 5'd0) mem[waddr_i] <= wdata_i;
endmodule

module data_mem #(
  parameter int DMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o
);
  // Word index comes from addr[7:2]; DMEM_WORDS is a power of two no larger than 64.
  localparam int AW = $clog2(DMEM_WORDS);

  logic [31:0]   mem2 [DMEM_WORDS];
  logic [AW-1:0] idx;
  logic          unused_addr;

  assign idx         = addr_i[2 +: AW];
  assign unused_addr = ^{addr_i[31:2+AW], addr_i[1:0]};
  assign rdata_o     = mem2[idx];

  always_ff @(posedge clk)
    if (we_i) mem2[idx] <= wdata_i;
endmodule

// File: rtl/mips_datapath.sv
// Single-cycle MIPS subset datapath: add/sub/and/or/slt, addi, lw, sw, beq, j.
module mips_datapath
  import mips_datapath_pkg::*;
#(
  parameter int IMEM_BYTES = 256,
  parameter int DMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pruebaInstruccion,
  output logic [31:0] pruebaDatoSalida,
  output logic [31:0] direccionASaltar,
  output logic        selMux5db,
  output logic        jumpSalida
);
  logic [31:0] pc_q, pc_d, instr, pc4, simm, j_target;
  logic [31:0] rdata1, rdata2, alu_b, alu_res, mem_rdata, wb_data;
  logic [4:0]  wreg;
  logic        reg_we, reg_dst_rd, alu_src_imm, mem_to_reg, mem_we, branch, jump, zero;
  alu_ctl_e    alu_ctl;

  instr_mem #(.IMEM_BYTES(IMEM_BYTES)) p3 (
    .pc_i    (pc_q),
    .instr_o (instr)
  );

  always_comb begin
    reg_we      = 1'b0;
    reg_dst_rd  = 1'b0;
    alu_src_imm = 1'b0;
    mem_to_reg  = 1'b0;
    mem_we      = 1'b0;
    branch      = 1'b0;
    jump        = 1'b0;
    alu_ctl     = ALU_ADD;
    case (instr[31:26])
      OP_RTYPE: begin
        reg_dst_rd = 1'b1;
        case (instr[5:0])
          FN_ADD: begin reg_we = 1'b1; alu_ctl = ALU_ADD; end
          FN_SUB: begin reg_we = 1'b1; alu_ctl = ALU_SUB; end
          FN_AND: begin reg_we = 1'b1; alu_ctl = ALU_AND; end
          FN_OR:  begin reg_we = 1'b1; alu_ctl = ALU_OR;  end
          FN_SLT: begin reg_we = 1'b1; alu_ctl = ALU_SLT; end
          FN_NOP: ;
          default: ;
        endcase
      end
      OP_ADDI: begin reg_we = 1'b1; alu_src_imm = 1'b1; end
      OP_LW:   begin reg_we = 1'b1; alu_src_imm = 1'b1; mem_to_reg = 1'b1; end
      OP_SW:   begin mem_we = 1'b1; alu_src_imm = 1'b1; end
      OP_BEQ:  begin branch = 1'b1; alu_ctl = ALU_SUB; end
      OP_J:    jump = 1'b1;
      default: ;
    endcase
  end

  assign simm  = {{16{instr[15]}}, instr[15:0]};
  assign wreg  = reg_dst_rd ? instr[15:11] : instr[20:16];

  // Writes are gated by rst_n so a reset held across an edge leaves state untouched.
  reg_bank p7 (
    .clk      (clk),
    .we_i     (reg_we & rst_n),
    .waddr_i  (wreg),
    .wdata_i  (wb_data),
    .raddr1_i (instr[25:21]),
    .raddr2_i (instr[20:16]),
    .rdata1_o (rdata1),
    .rdata2_o (rdata2)
  );

  assign alu_b   = alu_src_imm ? simm : rdata2;
  assign alu_res = alu_op(alu_ctl, rdata1, alu_b);
  assign zero    = (alu_res == 32'd0);

  data_mem #(.DMEM_WORDS(DMEM_WORDS)) p16 (
    .clk     (clk),
    .we_i    (mem_we & rst_n),
    .addr_i  (alu_res),
    .wdata_i (rdata2),
    .rdata_o (mem_rdata)
  );

  assign wb_data  = mem_to_reg ? mem_rdata : alu_res;
  assign pc4      = pc_q + 32'd4;
  assign j_target = {pc4[31:28], instr[25:0], 2'b00};

  assign pruebaInstruccion = instr;
  assign pruebaDatoSalida  = wb_data;
  assign direccionASaltar  = pc4 + {simm[29:0], 2'b00};
  assign selMux5db         = branch & zero;
  assign jumpSalida        = jump;

  // Jump wins over a taken branch.
  assign pc_d = jump ? j_target : (selMux5db ? direccionASaltar : pc4);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pc_q <= 32'd0;
    else        pc_q <= pc_d;

endmodule

// File: tb/tb_mips_datapath.sv
// Directed + random checks of mips_datapath against an instruction-level reference model.
module tb_mips_datapath;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pruebaInstruccion, pruebaDatoSalida, direccionASaltar;
  logic        selMux5db, jumpSalida;

  int checks = 0;
  int errors = 0;

  mips_datapath #(.IMEM_BYTES(256), .DMEM_WORDS(64)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .pruebaInstruccion (pruebaInstruccion),
    .pruebaDatoSalida  (pruebaDatoSalida),
    .direccionASaltar  (direccionASaltar),
    .selMux5db         (selMux5db),
    .jumpSalida        (jumpSalida)
  );

  always #5 clk = ~clk;

  // Reference machine state
  logic [7:0]  m_imem [256];
  logic [31:0] m_reg  [32];
  logic [31:0] m_dmem [64];
  logic [31:0] m_pc;

  // Expected effects of the instruction at m_pc
  logic [31:0] e_ins, e_dout, e_bt, e_npc, e_rval, e_mval;
  logic        e_dchk, e_sel, e_jmp, e_rwe, e_mwe;
  logic [4:0]  e_rdst;
  logic [5:0]  e_midx;

  // Outputs observed during the last executed step
  logic [31:0] o_dout, o_bt;
  logic        o_sel, o_jmp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(logic [25:0] t);
    return {6'h02, t};
  endfunction

  task automatic put(input logic [31:0] addr, input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      logic [7:0] a, b;
      a = 8'(addr + 32'(k));
      b = 8'(w >> (24 - 8 * k));
      m_imem[a] = b;
      dut.p3.MR[a] = b;
    end
  endtask

  task automatic set_reg(input logic [4:0] r, input logic [31:0] v);
    m_reg[r] = (r == 5'd0) ? 32'd0 : v;
    dut.p7.mem[r] = m_reg[r];
  endtask

  task automatic set_mem(input logic [5:0] i, input logic [31:0] v);
    m_dmem[i] = v;
    dut.p16.mem2[i] = v;
  endtask

  function automatic logic [31:0] word_at(logic [31:0] addr);
    return {m_imem[8'(addr)], m_imem[8'(addr + 1)], m_imem[8'(addr + 2)], m_imem[8'(addr + 3)]};
  endfunction

  task automatic model_eval();
    logic [31:0] a, b, simm, pc4, addr;
    e_ins = word_at(m_pc);
    a     = m_reg[e_ins[25:21]];
    b     = m_reg[e_ins[20:16]];
    simm  = 32'($signed(e_ins[15:0]));
    pc4   = m_pc + 32'd4;
    e_bt  = pc4 + simm * 4;
    e_npc = pc4;
    e_dout = 32'd0; e_rval = 32'd0; e_mval = 32'd0;
    e_dchk = 1'b0; e_sel = 1'b0; e_jmp = 1'b0; e_rwe = 1'b0; e_mwe = 1'b0;
    e_rdst = 5'd0; e_midx = 6'd0;
    case (e_ins[31:26])
      6'h00: begin
        e_rdst = e_ins[15:11];
        e_rwe  = 1'b1;
        e_dchk = 1'b1;
        case (e_ins[5:0])
          6'h20: e_rval = a + b;
          6'h22: e_rval = a - b;
          6'h24: e_rval = a & b;
          6'h25: e_rval = a | b;
          6'h2a: e_rval = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: begin e_rwe = 1'b0; e_dchk = 1'b0; end
        endcase
        e_dout = e_rval;
      end
      6'h08: begin
        e_rdst = e_ins[20:16]; e_rwe = 1'b1; e_rval = a + simm; e_dout = e_rval; e_dchk = 1'b1;
      end
      6'h23: begin
        addr = a + simm;
        e_rdst = e_ins[20:16]; e_rwe = 1'b1;
        e_rval = m_dmem[6'((addr / 4) % 64)];
        e_dout = e_rval; e_dchk = 1'b1;
      end
      6'h2b: begin
        addr = a + simm;
        e_mwe = 1'b1; e_midx = 6'((addr / 4) % 64); e_mval = b;
        e_dout = addr; e_dchk = 1'b1;
      end
      6'h04: begin
        e_dout = a - b; e_dchk = 1'b1;
        e_sel  = (a == b);
        if (e_sel) e_npc = e_bt;
      end
      6'h02: begin
        e_jmp = 1'b1;
        e_npc = {pc4[31:28], e_ins[25:0], 2'b00};
      end
      default: ;
    endcase
  endtask

  task automatic cmp_outputs();
    chk("instr", pruebaInstruccion, e_ins);
    chk("branch_target", direccionASaltar, e_bt);
    chk("branch_sel", 32'(selMux5db), 32'(e_sel));
    chk("jump", 32'(jumpSalida), 32'(e_jmp));
    if (e_dchk) chk("wb_data", pruebaDatoSalida, e_dout);
  endtask

  // One instruction: compare outputs mid-cycle, advance model at the edge, compare written state.
  task automatic step();
    @(negedge clk);
    model_eval();
    o_dout = pruebaDatoSalida; o_bt = direccionASaltar; o_sel = selMux5db; o_jmp = jumpSalida;
    cmp_outputs();
    @(posedge clk);
    if (e_rwe && e_rdst != 5'd0) m_reg[e_rdst] = e_rval;
    if (e_mwe) m_dmem[e_midx] = e_mval;
    m_pc = e_npc;
    #1;
    if (e_rwe) chk("reg_write", dut.p7.mem[e_rdst], m_reg[e_rdst]);
    if (e_mwe) chk("mem_write", dut.p16.mem2[e_midx], m_dmem[e_midx]);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rs, rt, rd;
    logic [15:0] off;
    logic [31:0] w;
    rs  = 5'($urandom_range(0, 7));
    rt  = 5'($urandom_range(0, 7));
    rd  = 5'($urandom_range(0, 7));
    off = 16'($urandom_range(0, 16)) - 16'd8;
    case ($urandom_range(0, 11))
      0:  w = enc_r(rs, rt, rd, 6'h20);
      1:  w = enc_r(rs, rt, rd, 6'h22);
      2:  w = enc_r(rs, rt, rd, 6'h24);
      3:  w = enc_r(rs, rt, rd, 6'h25);
      4:  w = enc_r(rs, rt, rd, 6'h2a);
      5:  w = enc_i(6'h08, rs, rt, 16'($urandom));
      6:  w = enc_i(6'h23, rs, rt, 16'($urandom_range(0, 255)));
      7:  w = enc_i(6'h2b, rs, rt, 16'($urandom_range(0, 255)));
      8:  w = enc_i(6'h04, rs, ($urandom_range(0, 1) == 1) ? rs : rt, off);
      9:  w = enc_j(26'($urandom));
      10: w = enc_r(rs, rt, rd, 6'h00);
      default: w = ($urandom_range(0, 1) == 1) ? enc_r(rs, rt, rd, 6'h3f) : {6'h3f, 26'($urandom)};
    endcase
    return w;
  endfunction

  initial begin
    // Directed program
    for (int i = 0; i < 64; i++) put(32'(i * 4), 32'd0);
    for (int r = 0; r < 32; r++) set_reg(5'(r), 32'd0);
    for (int i = 0; i < 64; i++) set_mem(6'(i), 32'd0);
    set_reg(5'd1, 32'd5);
    set_reg(5'd2, 32'd7);
    put(32'h00, enc_r(5'd1, 5'd2, 5'd3, 6'h20));          // add r3,r1,r2
    put(32'h04, enc_i(6'h2b, 5'd0, 5'd3, 16'd8));         // sw r3,8(r0)
    put(32'h08, enc_i(6'h04, 5'd1, 5'd1, 16'd3));         // beq r1,r1,+3
    put(32'h18, enc_j(26'h000010));                       // j 0x10
    put(32'h40, enc_i(6'h23, 5'd0, 5'd4, 16'd8));         // lw r4,8(r0)
    put(32'h44, enc_i(6'h04, 5'd1, 5'd2, 16'd5));         // beq r1,r2,+5
    put(32'h48, enc_i(6'h08, 5'd0, 5'd2, 16'hffff));      // addi r2,r0,-1
    put(32'h4c, enc_r(5'd2, 5'd1, 5'd5, 6'h2a));          // slt r5,r2,r1
    put(32'h50, enc_i(6'h08, 5'd0, 5'd0, 16'd9));         // addi r0,r0,9
    m_pc = 32'd0;

    @(posedge clk);
    #2;
    model_eval();
    cmp_outputs();
    chk("reset_instr", pruebaInstruccion, 32'h00221820);
    rst_n = 1'b1;

    step();
    chk("add_dout", o_dout, 32'd12);
    chk("add_r3", dut.p7.mem[3], 32'd12);
    chk("add_next_pc", pruebaInstruccion, word_at(32'h04));
    step();
    chk("sw_mem2", dut.p16.mem2[2], 32'd12);
    step();
    chk("beq_taken_sel", 32'(o_sel), 32'd1);
    chk("beq_target", o_bt, 32'd24);
    chk("beq_next_pc", pruebaInstruccion, word_at(32'd24));
    step();
    chk("j_flag", 32'(o_jmp), 32'd1);
    chk("j_next_pc", pruebaInstruccion, word_at(32'h40));
    step();
    chk("lw_dout", o_dout, 32'd12);
    chk("lw_r4", dut.p7.mem[4], 32'd12);
    step();
    chk("beq_not_taken_sel", 32'(o_sel), 32'd0);
    chk("beq_not_taken_pc", pruebaInstruccion, word_at(32'h48));
    step();
    step();
    chk("slt_r5", dut.p7.mem[5], 32'd1);
    step();
    chk("r0_stays_zero", dut.p7.mem[0], 32'd0);

    // Reset asserted between edges, then held across an edge
    #3;
    rst_n = 1'b0;
    m_pc  = 32'd0;
    #1;
    chk("midreset_instr", pruebaInstruccion, word_at(32'd0));
    for (int r = 1; r < 6; r++) chk("midreset_reg", dut.p7.mem[r], m_reg[r]);
    @(posedge clk);
    #1;
    chk("reset_hold_r3", dut.p7.mem[3], 32'd12);
    chk("reset_hold_instr", pruebaInstruccion, word_at(32'd0));
    #1;
    rst_n = 1'b1;
    step();
    chk("post_reset_r3", dut.p7.mem[3], 32'd4);

    // Random programs
    rst_n = 1'b0;
    for (int i = 0; i < 64; i++) put(32'(i * 4), rand_instr());
    for (int r = 0; r < 32; r++) set_reg(5'(r), $urandom);
    for (int i = 0; i < 64; i++) set_mem(6'(i), $urandom);
    m_pc = 32'd0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int n = 0; n < 400; n++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
